// File: rtl/pipelined_add_sub_pkg.sv
// Shared types and elaboration helpers for the pipelined adder/subtractor.
// Chunk width and configuration legality are derived from WIDTH and STAGES.
package pipelined_add_sub_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_STAGES = 4;
    localparam int DEF_TAG_W  = 4;

    typedef struct packed {
        logic cout;
        logic ovf;
        logic zero;
    } flags_t;

    function automatic int chunk_w(int width, int stages);
        return width / stages;
    endfunction

    function automatic bit cfg_ok(int width, int stages);
        return (stages >= 1) && (stages <= width) && (width % stages == 0);
    endfunction

    localparam int DEF_CW = chunk_w(DEF_WIDTH, DEF_STAGES);

endpackage

// File: rtl/pipelined_add_sub_if.sv
// Operand and result channels of the pipelined adder/subtractor.
// The slave side is the arithmetic block, the master side its environment.
interface pipelined_add_sub_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) ();

    logic             InValid;
    logic             InReady;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             Sub;
    logic [TAG_W-1:0] InTag;

    logic             OutValid;
    logic             OutReady;
    logic [WIDTH-1:0] Sum;
    logic             Cout;
    logic             Overflow;
    logic             Zero;
    logic [TAG_W-1:0] OutTag;

    modport slave (
        input  InValid, A, B, Cin, Sub, InTag, OutReady,
        output InReady, OutValid, Sum, Cout, Overflow, Zero, OutTag
    );

    modport master (
        output InValid, A, B, Cin, Sub, InTag, OutReady,
        input  InReady, OutValid, Sum, Cout, Overflow, Zero, OutTag
    );

endinterface

// File: rtl/pipelined_add_sub_chunk_adder.sv
// Combinational CW-bit ripple adder made of full-adder cells.
// Also exposes the carry into its MSB so the top chunk can flag overflow.
module pipelined_add_sub_chunk_adder #(
    parameter int CW = 8
) (
    input  logic [CW-1:0] a_i,
    input  logic [CW-1:0] b_i,
    input  logic          c_i,
    output logic [CW-1:0] s_o,
    output logic          co_o,
    output logic          cm_o
);

    logic [CW:0] c;

    assign c[0] = c_i;

    for (genvar i = 0; i < CW; i++) begin : g_fa
        logic p;
        assign p        = a_i[i] ^ b_i[i];
        assign s_o[i]   = p ^ c[i];
        assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & p);
    end

    assign co_o = c[CW];
    assign cm_o = c[CW-1];

endmodule

// File: rtl/pipelined_add_sub.sv
// Pipelined add/subtract: one CW-bit chunk per stage, carry registered
// between stages, operands skewed in and result chunks deskewed out.
module pipelined_add_sub
    import pipelined_add_sub_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES,
    parameter int TAG_W  = DEF_TAG_W
) (
    input  logic               Clk,
    input  logic               Rst_n,
    pipelined_add_sub_if.slave io
);

    localparam int CW = chunk_w(WIDTH, STAGES);

    if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
        $error("pipelined_add_sub: WIDTH must be a multiple of STAGES");
    end

    logic [WIDTH-1:0] st_a [STAGES];
    logic [WIDTH-1:0] st_b [STAGES];
    logic [WIDTH-1:0] st_s [STAGES];
    logic             st_c [STAGES];
    logic             st_v [STAGES];
    logic [TAG_W-1:0] st_t [STAGES];
    logic             adv  [STAGES];
    flags_t           flg_q;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] a_in;
        logic [WIDTH-1:0] b_in;
        logic [WIDTH-1:0] s_in;
        logic [WIDTH-1:0] s_d;
        logic             c_in;
        logic             v_in;
        logic [TAG_W-1:0] t_in;
        logic [CW-1:0]    sc;
        logic             co;
        logic             cm;
        logic             ld;
        logic             v_q;
        logic [WIDTH-1:0] s_q;
        logic [TAG_W-1:0] t_q;

        // B is inverted once on entry so later stages only ever add
        if (k == 0) begin : g_head
            assign a_in = io.A;
            assign b_in = io.B ^ {WIDTH{io.Sub}};
            assign s_in = '0;
            assign c_in = io.Cin ^ io.Sub;
            assign v_in = io.InValid;
            assign t_in = io.InTag;
        end else begin : g_body
            assign a_in = st_a[k-1];
            assign b_in = st_b[k-1];
            assign s_in = st_s[k-1];
            assign c_in = st_c[k-1];
            assign v_in = st_v[k-1];
            assign t_in = st_t[k-1];
        end

        pipelined_add_sub_chunk_adder #(
            .CW (CW)
        ) u_add (
            .a_i  (a_in[k*CW +: CW]),
            .b_i  (b_in[k*CW +: CW]),
            .c_i  (c_in),
            .s_o  (sc),
            .co_o (co),
            .cm_o (cm)
        );

        always_comb begin
            s_d              = s_in;
            s_d[k*CW +: CW]  = sc;
        end

        assign ld = adv[k] & v_in;

        always_ff @(posedge Clk or negedge Rst_n) begin
            if (!Rst_n) begin
                v_q <= 1'b0;
                s_q <= '0;
                t_q <= '0;
            end else begin
                if (adv[k]) begin
                    v_q <= v_in;
                end
                if (ld) begin
                    s_q <= s_d;
                    t_q <= t_in;
                end
            end
        end

        assign st_v[k] = v_q;
        assign st_s[k] = s_q;
        assign st_t[k] = t_q;

        if (k < STAGES - 1) begin : g_skew
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] b_q;
            logic             c_q;

            always_ff @(posedge Clk or negedge Rst_n) begin
                if (!Rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                    c_q <= 1'b0;
                end else if (ld) begin
                    a_q <= a_in;
                    b_q <= b_in;
                    c_q <= co;
                end
            end

            assign st_a[k] = a_q;
            assign st_b[k] = b_q;
            assign st_c[k] = c_q;
            assign adv[k]  = !v_q || adv[k+1];
        end else begin : g_tail
            always_ff @(posedge Clk or negedge Rst_n) begin
                if (!Rst_n) begin
                    flg_q <= '0;
                end else if (ld) begin
                    flg_q.cout <= co;
                    flg_q.ovf  <= co ^ cm;
                    flg_q.zero <= (s_d == '0);
                end
            end

            assign st_a[k] = '0;
            assign st_b[k] = '0;
            assign st_c[k] = 1'b0;
            assign adv[k]  = !v_q || io.OutReady;
        end
    end

    assign io.InReady  = adv[0];
    assign io.OutValid = st_v[STAGES-1];
    assign io.Sum      = st_s[STAGES-1];
    assign io.OutTag   = st_t[STAGES-1];
    assign io.Cout     = flg_q.cout;
    assign io.Overflow = flg_q.ovf;
    assign io.Zero     = flg_q.zero;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Bench for pipelined_add_sub: directed vectors, random stream,
// backpressure and mid-stream reset, checked through a result queue.
module tb_pipelined_add_sub;

    localparam int STAGES = 4;

    typedef struct packed {
        logic [3:0]  tag;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic [31:0] sum;
    } res_t;

    typedef struct {
        res_t r;
        int   t;
    } sb_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [3:0]  tag;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    pipelined_add_sub_if #(.WIDTH(32), .TAG_W(4)) io ();

    pipelined_add_sub #(
        .WIDTH  (32),
        .STAGES (STAGES),
        .TAG_W  (4)
    ) dut (
        .Clk   (clk),
        .Rst_n (rst_n),
        .io    (io.slave)
    );

    sb_t  q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    bit   chk_lat = 1'b1;
    bit   prev_stall = 1'b0;
    res_t prev_out;
    bit   last_acc;
    bit   last_inrdy;
    res_t pend;
    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, got, want);
        end
    endtask

    function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic sub,
                                   input logic [3:0] tag);
        logic [31:0] bb;
        logic [32:0] f;
        res_t r;
        bb     = b ^ {32{sub}};
        f      = {1'b0, a} + {1'b0, bb} + 33'(cin ^ sub);
        r.sum  = f[31:0];
        r.cout = f[32];
        r.ovf  = (a[31] == bb[31]) && (f[31] != a[31]);
        r.zero = (f[31:0] == 32'h0);
        r.tag  = tag;
        return r;
    endfunction

    function automatic res_t outs();
        res_t r;
        r.tag  = io.OutTag;
        r.cout = io.Cout;
        r.ovf  = io.Overflow;
        r.zero = io.Zero;
        r.sum  = io.Sum;
        return r;
    endfunction

    task automatic set_op(input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic sub,
                          input logic [3:0] tag, input res_t r);
        io.A       = a;
        io.B       = b;
        io.Cin     = cin;
        io.Sub     = sub;
        io.InTag   = tag;
        io.InValid = 1'b1;
        pend       = r;
    endtask

    task automatic set_rand(input logic [3:0] tag);
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        a   = $urandom;
        b   = $urandom;
        cin = 1'($urandom_range(0, 1));
        sub = 1'($urandom_range(0, 1));
        set_op(a, b, cin, sub, tag, model(a, b, cin, sub, tag));
    endtask

    // Called right after a falling edge with inputs already driven
    task automatic tick();
        res_t got;
        sb_t  e;
        #1;
        got        = outs();
        last_inrdy = io.InReady;
        if (io.OutValid && io.OutReady) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_result: got %h required none", got);
            end else begin
                e = q.pop_front();
                check("result", 64'(got), 64'(e.r));
                if (chk_lat) check("latency", 64'(cyc - e.t), 64'(STAGES));
            end
        end
        if (io.OutValid && !io.OutReady && prev_stall)
            check("stall_stable", 64'(got), 64'(prev_out));
        prev_stall = io.OutValid && !io.OutReady;
        prev_out   = got;
        last_acc   = io.InValid && io.InReady;
        if (last_acc) q.push_back('{r: pend, t: cyc});
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain();
        int n;
        n = 0;
        io.InValid = 1'b0;
        while (q.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d pending required 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        vecs[0]  = '{32'h0000_0005, 32'h0000_0003, 0, 0, 3,
                     32'h0000_0008, 0, 0, 0};
        vecs[1]  = '{32'hFFFF_FFFF, 32'h0000_0001, 0, 0, 1,
                     32'h0000_0000, 1, 0, 1};
        vecs[2]  = '{32'h7FFF_FFFF, 32'h0000_0001, 0, 0, 2,
                     32'h8000_0000, 0, 1, 0};
        vecs[3]  = '{32'h0000_0005, 32'h0000_0007, 0, 1, 4,
                     32'hFFFF_FFFE, 0, 0, 0};
        vecs[4]  = '{32'h0000_0007, 32'h0000_0005, 1, 1, 5,
                     32'h0000_0001, 1, 0, 0};
        vecs[5]  = '{32'h8000_0000, 32'h0000_0001, 0, 1, 6,
                     32'h7FFF_FFFF, 1, 1, 0};
        vecs[6]  = '{32'h0000_0000, 32'h0000_0000, 0, 1, 7,
                     32'h0000_0000, 1, 0, 1};
        vecs[7]  = '{32'h0000_0001, 32'h0000_0001, 1, 0, 8,
                     32'h0000_0003, 0, 0, 0};
        vecs[8]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 9,
                     32'hFFFF_FFFF, 1, 0, 0};
        vecs[9]  = '{32'h00FF_FFFF, 32'h0000_0001, 0, 0, 10,
                     32'h0100_0000, 0, 0, 0};
        vecs[10] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, 0, 11,
                     32'hFFFF_FFFE, 0, 1, 0};
        vecs[11] = '{32'h8000_0000, 32'h8000_0000, 0, 0, 12,
                     32'h0000_0000, 1, 1, 1};

        io.InValid  = 1'b0;
        io.A        = '0;
        io.B        = '0;
        io.Cin      = 1'b0;
        io.Sub      = 1'b0;
        io.InTag    = '0;
        io.OutReady = 1'b1;

        repeat (2) @(negedge clk);
        #1;
        check("reset_outputs", 64'({io.OutValid, outs()}), 64'h0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("inready_after_reset", 64'(io.InReady), 64'h1);
        @(negedge clk);

        chk_lat = 1'b1;
        for (int i = 0; i < 12; i++) begin
            res_t r;
            r.sum  = vecs[i].sum;
            r.cout = vecs[i].cout;
            r.ovf  = vecs[i].ovf;
            r.zero = vecs[i].zero;
            r.tag  = vecs[i].tag;
            set_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
                   vecs[i].tag, r);
            tick();
            check("vec_accept", 64'(last_acc), 64'h1);
            drain();
        end

        for (int i = 0; i < 16; i++) begin
            set_rand(4'(i));
            tick();
            check("stream_accept", 64'(last_acc), 64'h1);
        end
        drain();

        begin
            int acc;
            chk_lat     = 1'b0;
            acc         = 0;
            io.OutReady = 1'b0;
            set_rand(4'(acc));
            for (int i = 0; i < 6; i++) begin
                tick();
                if (last_acc) begin
                    acc++;
                    set_rand(4'(acc));
                end
            end
            check("bp_accepted", 64'(acc), 64'h4);
            check("bp_inready", 64'(last_inrdy), 64'h0);
            io.OutReady = 1'b1;
            for (int i = 0; i < 4; i++) begin
                tick();
                check("bp_passthru_inready", 64'(last_inrdy), 64'h1);
                if (last_acc) begin
                    acc++;
                    set_rand(4'(acc));
                end
            end
            drain();
        end

        chk_lat = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_rand(4'(i));
            tick();
        end
        io.InValid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("reset_midstream", 64'({io.OutValid, outs()}), 64'h0);
        q.delete();
        prev_stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        set_op(32'h1, 32'h1, 1'b0, 1'b0, 4'd5,
               '{tag: 4'd5, cout: 1'b0, ovf: 1'b0, zero: 1'b0, sum: 32'h2});
        tick();
        check("post_reset_accept", 64'(last_acc), 64'h1);
        drain();
        repeat (6) tick();

        check("sb_empty", 64'(q.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipelined_add_sub.md
Name: pipelined_add_sub

Overview:
- Parametrised, pipelined successor to the team's 32-bit ripple-carry adder.
- The WIDTH-bit operation is split into STAGES equal chunks, with one registered chunk per cycle and the carry passed between stages.
- Supports add and subtract, carry/borrow-in, signed overflow and zero flags, and a sideband tag.
- Fed by operand producers; drains into the datapath through a valid/ready handshake with backpressure.

Parameters:
- WIDTH, 32, operand/result width in bits; must be divisible by STAGES.
- STAGES, 4, pipeline depth; chunk width CW = WIDTH/STAGES; range 1..WIDTH.
- TAG_W, 4, width of the opaque tag carried alongside each operation.

Ports:
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  asynchronous active-low reset.
- InValid  input  1  operands presented.
- InReady  output  1  block accepts operands this cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- Cin  input  1  carry-in (add) / borrow-in (sub).
- Sub  input  1  0 = add, 1 = subtract.
- InTag  input  TAG_W  sideband tag.
- OutValid  output  1  result available.
- OutReady  input  1  consumer accepts result.
- Sum  output  WIDTH  result.
- Cout  output  1  carry out of MSB.
- Overflow  output  1  signed overflow.
- Zero  output  1  Sum == 0.
- OutTag  output  TAG_W  tag of the result.

Behaviour:
- Operation: result = A + (B ^ {WIDTH{Sub}}) + (Cin ^ Sub), computed modulo 2^WIDTH.
  - Sub=1, Cin=0 gives A-B.
  - Sub=1, Cin=1 gives A-B-1 (borrow-in).
- Cout: the raw carry out of bit WIDTH-1. For subtract, Cout=1 means no borrow.
- Overflow: carry into the MSB XOR carry out of the MSB.
- Zero: asserted when the full WIDTH-bit Sum is all zeros.
- Pipeline stages:
  - Stage k (0..STAGES-1) computes bits [k*CW +: CW] using the registered carry from stage k-1. Stage 0 uses Cin^Sub.
  - Upper operand chunks are carried forward in skew registers.
  - Lower result chunks are carried forward in deskew registers, so all Sum bits of one operation emerge together.
- Latency: exactly STAGES cycles from an input handshake (InValid&InReady) to OutValid, when there are no stalls.
- Throughput: one operation per cycle.
- Per-stage valid bit: stage k advances when it is empty or stage k+1 advances. The last stage advances when !OutValid or OutReady.
- Bubbles collapse: an empty stage accepts new data even while downstream stages are stalled.
- InReady = !valid[0] || advance[0]. It is combinational from OutReady through the chain; this is acceptable.
- Output stability: while OutValid && !OutReady, Sum, Cout, Overflow, Zero and OutTag hold stable.
- InValid with InReady=0: no capture; the producer holds its inputs.
- Simultaneous events: OutReady and InValid in the same cycle with a full pipe → one result leaves, one operation enters, with no bubble.
- Reset (asynchronous, any time, including mid-operation):
  - All valid bits clear; OutValid=0.
  - Sum=0, Cout=0, Overflow=0, Zero=0, OutTag=0.
  - All data and carry registers clear to 0. In-flight operations are discarded.
  - InReady=1 from the first cycle after reset release.
- STAGES=1: a single registered full-width adder with latency 1.
- Boundary values: wrap-around (max+1) gives Sum=0, Cout=1, Zero=1. Overflow is evaluated independently of Cout.

Decomposition:
- Shared package:
  - flag struct typedef (Cout, Overflow, Zero);
  - an elaboration check that WIDTH % STAGES == 0;
  - localparam for chunk width.
- Sub-module chunk_adder: parameter CW. Combinational CW-bit adder built from full-adder cells. Outputs sum chunk, carry out, and carry into its MSB (for overflow in the top stage). It is instantiated STAGES times by generate.

Test Plan:
- Reset, then a single op A=0x0000_0005, B=0x0000_0003, Sub=0, Cin=0, InTag=3 → after 4 cycles OutValid=1, Sum=0x0000_0008, Cout=0, Overflow=0, Zero=0, OutTag=3.
- Carry ripple across all stage boundaries: A=0xFFFF_FFFF, B=0x0000_0001 → Sum=0x0000_0000, Cout=1, Zero=1, Overflow=0. Then A=0x7FFF_FFFF, B=1 → Sum=0x8000_0000, Overflow=1, Cout=0.
- Subtract: A=5, B=7, Sub=1, Cin=0 → Sum=0xFFFF_FFFE, Cout=0 (borrow). A=7, B=5, Sub=1, Cin=1 → Sum=1, Cout=1.
- Back-to-back stream of 16 random ops with OutReady=1 → one result per cycle in order, tags 0..15 matching a reference model, latency 4.
- Backpressure: hold OutReady=0 for 6 cycles while InValid=1 → InReady drops after 4 accepted ops, outputs stay stable, nothing is lost or duplicated. On release, ordering is preserved.
- Assert Rst_n low mid-stream with 3 ops in flight → OutValid=0 and all outputs 0 immediately. After release, a new op A=1, B=1 yields Sum=2 after 4 cycles, with no stale results.
